// File: rtl/axi_llc_pkg.sv
// Shared types and helpers for the ARCANE descriptor <-> AXI conversion blocks.
package axi_llc_pkg;

   localparam int unsigned ArcaneAddrWidth    = 64;
   localparam int unsigned ArcaneLineCntWidth = 16;
   localparam int unsigned ArcaneIdWidth      = 6;

   // Multi-line transfer descriptor: line-aligned start address, line count, AXI ID.
   typedef struct packed {
      logic [ArcaneAddrWidth-1:0]    addr;
      logic [ArcaneLineCntWidth-1:0] lines;
      logic [ArcaneIdWidth-1:0]      id;
   } arcane_xfer_desc_t;

   localparam logic [1:0] AxiBurstIncr = 2'b01;

   // Number of whole lines that fit between page_off and the next 4 KiB boundary.
   function automatic logic [12:0] arcane_max_lines(input logic [11:0] page_off,
                                                    input int unsigned line_shift);
      logic [12:0] room;
      room = 13'd4096 - {1'b0, page_off};
      return room >> line_shift;
   endfunction

endpackage

// File: rtl/axi_llc_arcane_txn_cnt.sv
// Saturating up/down counter of outstanding AXI bursts (0..MaxCnt).
// A simultaneous increment and decrement leaves the count unchanged.
module axi_llc_arcane_txn_cnt #(
   parameter int unsigned MaxCnt = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic dec_i,
   output logic max_o,
   output logic empty_o,
   output logic max_next_o
);

   localparam int unsigned CntWidth = $clog2(MaxCnt + 1);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxCnt);

   logic [CntWidth-1:0] cnt_reg;
   logic [CntWidth-1:0] cnt_next;

   // Next count: saturate at both ends, decrement at zero is dropped.
   always_comb begin
      cnt_next = cnt_reg;
      if (inc_i && !dec_i && cnt_reg != CntMax) begin
         cnt_next = cnt_reg + 1'b1;
      end else if (dec_i && !inc_i && cnt_reg != '0) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign max_o      = (cnt_reg == CntMax);
   assign empty_o    = (cnt_reg == '0);
   assign max_next_o = (cnt_next == CntMax);

   // A completion with nothing outstanding means the memory side misbehaved.
   assert property (@(posedge clk_i) disable iff (!rst_ni) dec_i |-> !empty_o);

endmodule

// File: rtl/axi_llc_arcane_desc2axi.sv
// Turns ARCANE multi-line descriptors into AXI4 AR/AW INCR bursts of at most
// 256 beats that never cross a 4 KiB page, and tracks outstanding bursts.
// ax_chan_o layout (MSB first): id, addr, len, size, burst, lock, cache, prot, qos, region.
module axi_llc_arcane_desc2axi
   import axi_llc_pkg::*;
#(
   parameter int unsigned Write        = 0,
   parameter int unsigned AddrWidth    = 64,
   parameter int unsigned IdWidth      = 6,
   parameter int unsigned BeatBytes    = 8,
   parameter int unsigned BeatsPerLine = 8,
   parameter int unsigned LineCntWidth = 16,
   parameter int unsigned MaxTrans     = 4
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic [AddrWidth+LineCntWidth+IdWidth-1:0]  desc_i,
   input  logic                                       desc_valid_i,
   output logic                                       desc_ready_o,
   output logic [IdWidth+AddrWidth+28:0]              ax_chan_o,
   output logic                                       ax_valid_o,
   input  logic                                       ax_ready_i,
   input  logic                                       done_i,
   output logic                                       busy_o
);

   localparam int unsigned LineBytes     = BeatBytes * BeatsPerLine;
   localparam int unsigned LineShift     = $clog2(LineBytes);
   localparam int unsigned BeatShift     = $clog2(BeatsPerLine);
   localparam int unsigned SizeVal       = $clog2(BeatBytes);
   localparam int unsigned MaxBurstLines = 256 / BeatsPerLine;
   localparam int unsigned LW            = LineCntWidth + 1;
   localparam int unsigned DW            = AddrWidth + LineCntWidth + IdWidth;

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StSplit = 1'b1;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
   } ax_t;

   logic [0:0]              state_reg, state_next;
   logic [AddrWidth-1:0]    addr_reg, addr_next;
   logic [LineCntWidth-1:0] rem_reg, rem_next;
   logic [LW-1:0]           n_reg, n_next;
   logic [IdWidth-1:0]      id_reg, id_next;
   logic                    ax_valid_reg, ax_valid_next;
   ax_t                     ax_chan_reg, ax_chan_next;

   logic [AddrWidth-1:0]    desc_addr, adv_addr, calc_addr;
   logic [LineCntWidth-1:0] desc_lines, adv_rem, calc_rem;
   logic [IdWidth-1:0]      desc_id, calc_id;
   logic [LW-1:0]           calc_n;
   logic [LW+7:0]           calc_beats;
   logic [7:0]              calc_len;
   logic                    ax_hs, load;
   logic                    cnt_max, cnt_empty, cnt_max_next;

   assign desc_addr  = desc_i[DW-1 -: AddrWidth];
   assign desc_lines = desc_i[IdWidth +: LineCntWidth];
   assign desc_id    = desc_i[IdWidth-1:0];

   assign ax_hs = ax_valid_reg && ax_ready_i;

   // Position after the burst currently on the bus.
   assign adv_addr = addr_reg + (AddrWidth'(n_reg) << LineShift);
   assign adv_rem  = rem_reg - LineCntWidth'(n_reg);

   // The burst calculator sees either a fresh descriptor or the advanced position,
   // so the next payload can be registered in the same cycle as the handshake.
   assign calc_addr = (state_reg == StIdle) ? (desc_addr & ~AddrWidth'(LineBytes - 1)) : adv_addr;
   assign calc_rem  = (state_reg == StIdle) ? desc_lines : adv_rem;
   assign calc_id   = (state_reg == StIdle) ? desc_id : id_reg;

   // Burst size in lines: min of remaining, 256-beat cap and room left in the 4 KiB page.
   always_comb begin
      logic [LW-1:0] lim_burst, lim_page;
      lim_burst = LW'(MaxBurstLines);
      lim_page  = LW'(arcane_max_lines(calc_addr[11:0], LineShift));
      calc_n    = LW'(calc_rem);
      if (lim_burst < calc_n) calc_n = lim_burst;
      if (lim_page < calc_n)  calc_n = lim_page;
      calc_beats = (LW+8)'(calc_n) << BeatShift;
      calc_len   = 8'(calc_beats - (LW+8)'(1));
   end

   axi_llc_arcane_txn_cnt #(
      .MaxCnt (MaxTrans)
   ) i_txn_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (ax_hs),
      .dec_i      (done_i),
      .max_o      (cnt_max),
      .empty_o    (cnt_empty),
      .max_next_o (cnt_max_next)
   );

   // Splitting FSM: accept descriptor, then emit bursts until no lines remain.
   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      rem_next      = rem_reg;
      n_next        = n_reg;
      id_next       = id_reg;
      ax_valid_next = ax_valid_reg;
      ax_chan_next  = ax_chan_reg;
      load          = 1'b0;
      case (state_reg)
         StIdle: begin
            // Zero-line descriptors are consumed without producing a burst.
            if (desc_valid_i && desc_lines != '0) begin
               state_next = StSplit;
               load       = 1'b1;
            end
         end
         StSplit: begin
            if (ax_hs) begin
               if (adv_rem == '0) begin
                  state_next    = StIdle;
                  ax_valid_next = 1'b0;
               end else begin
                  load = 1'b1;
               end
            end else begin
               // A raised valid is held; a held-back one rises once the limit clears.
               ax_valid_next = ax_valid_reg | ~cnt_max_next;
            end
         end
         default: state_next = StIdle;
      endcase
      if (load) begin
         addr_next           = calc_addr;
         rem_next            = calc_rem;
         n_next              = calc_n;
         id_next             = calc_id;
         ax_valid_next       = ~cnt_max_next;
         ax_chan_next        = '0;
         ax_chan_next.id     = calc_id;
         ax_chan_next.addr   = calc_addr;
         ax_chan_next.len    = calc_len;
         ax_chan_next.size   = 3'(SizeVal);
         ax_chan_next.burst  = AxiBurstIncr;
      end
   end

   // State, position and registered AX request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg    <= StIdle;
         addr_reg     <= '0;
         rem_reg      <= '0;
         n_reg        <= '0;
         id_reg       <= '0;
         ax_valid_reg <= 1'b0;
         ax_chan_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         rem_reg      <= rem_next;
         n_reg        <= n_next;
         id_reg       <= id_next;
         ax_valid_reg <= ax_valid_next;
         ax_chan_reg  <= ax_chan_next;
      end
   end

   assign desc_ready_o = (state_reg == StIdle);
   assign ax_valid_o   = ax_valid_reg;
   assign ax_chan_o    = ax_chan_reg;
   assign busy_o       = (state_reg == StSplit) || !cnt_empty;

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      ax_valid_o && !ax_ready_i |=> ax_valid_o && $stable(ax_chan_o));
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      ax_valid_o |-> (int'(ax_chan_reg.addr[11:0]) + (int'(ax_chan_reg.len) + 1) * int'(BeatBytes)) <= 4096);
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      ax_valid_o |-> int'(ax_chan_reg.len) <= 255 && Write <= 1);
   assert property (@(posedge clk_i) disable iff (!rst_ni) ax_valid_o |-> !cnt_max);

endmodule
